// File: rtl/peripheral_dpram_generic_biu.sv
// Purpose : true dual-port byte-enabled RAM bus model; two ports share one array.
// Latency : write ack 1 cycle after accept; read data/valid RD_LATENCY cycles after accept.
// Backpres: none; each port accepts one request per cycle whenever rst is high.
//
// Ports (per port x in {a, b}):
//   x_req_i / x_we_i / x_be_i / x_addr_i / x_data_i : request, write flag, byte lanes, word address, write data
//   x_ack_o   : 1-cycle write acknowledge
//   x_valid_o : 1-cycle read-data strobe; x_data_o holds the last read word between strobes
// clk: rising-edge clock; rst: synchronous active-low reset (array contents survive reset).
// Optional macro PERIPHERAL_DPRAM_WRITE_THROUGH_EN: a cross-port read that collides with a
// write to the same word returns the merged (new) word instead of the pre-write contents.
module peripheral_dpram_generic_biu #(
    parameter int ALEN       = 10,
    parameter int XLEN       = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_req_i,
    input  logic                a_we_i,
    input  logic [XLEN/8-1:0]   a_be_i,
    input  logic [ALEN-1:0]     a_addr_i,
    input  logic [XLEN-1:0]     a_data_i,
    output logic                a_ack_o,
    output logic                a_valid_o,
    output logic [XLEN-1:0]     a_data_o,
    input  logic                b_req_i,
    input  logic                b_we_i,
    input  logic [XLEN/8-1:0]   b_be_i,
    input  logic [ALEN-1:0]     b_addr_i,
    input  logic [XLEN-1:0]     b_data_i,
    output logic                b_ack_o,
    output logic                b_valid_o,
    output logic [XLEN-1:0]     b_data_o
);

    localparam int NBL   = XLEN / 8;
    localparam int DEPTH = 1 << ALEN;

    generate
        if ((XLEN % 8) != 0) begin : g_bad_xlen
            $fatal(1, "peripheral_dpram_generic_biu: XLEN must be a multiple of 8");
        end
        if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
            $fatal(1, "peripheral_dpram_generic_biu: RD_LATENCY must be in 1..4");
        end
    endgenerate

    // Port 0 is A, port 1 is B throughout; A has lane priority on collisions.
    logic [1:0]      req;
    logic [1:0]      we;
    logic [NBL-1:0]  be   [2];
    logic [ALEN-1:0] addr [2];
    logic [XLEN-1:0] wdat [2];

    assign req     = {b_req_i, a_req_i};
    assign we      = {b_we_i, a_we_i};
    assign be[0]   = a_be_i;
    assign be[1]   = b_be_i;
    assign addr[0] = a_addr_i;
    assign addr[1] = b_addr_i;
    assign wdat[0] = a_data_i;
    assign wdat[1] = b_data_i;

    // Requests presented while in reset are dropped entirely.
    logic [1:0] wr_en;
    logic [1:0] rd_en;
    assign wr_en = req &  we & {2{rst}};
    assign rd_en = req & ~we & {2{rst}};

    logic [XLEN-1:0] mem_q [DEPTH];

    // Word captured into the read pipeline at the accept edge.
    logic [XLEN-1:0] rd_word [2];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_word[p] = mem_q[addr[p]];
`ifdef PERIPHERAL_DPRAM_WRITE_THROUGH_EN
            // B is applied first so A overrides on lanes both ports write.
            for (int w = 1; w >= 0; w--) begin
                for (int k = 0; k < NBL; k++) begin
                    if (w != p && wr_en[w] && addr[w] == addr[p] && be[w][k]) begin
                        rd_word[p][8*k +: 8] = wdat[w][8*k +: 8];
                    end
                end
            end
`endif
        end
    end

    // B lanes are scheduled first; a later A assignment to the same lane wins.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NBL; k++) begin
            if (wr_en[1] && be[1][k]) begin
                mem_q[addr[1]][8*k +: 8] <= wdat[1][8*k +: 8];
            end
            if (wr_en[0] && be[0][k]) begin
                mem_q[addr[0]][8*k +: 8] <= wdat[0][8*k +: 8];
            end
        end
    end

    logic [1:0] ack_d, ack_q;
    assign ack_d = wr_en;

    // Read pipeline per port; the last stage keeps its data when no valid arrives,
    // which gives the hold-last-value behaviour on x_data_o.
    logic [1:0]      pipe_vld_d [RD_LATENCY];
    logic [1:0]      pipe_vld_q [RD_LATENCY];
    logic [XLEN-1:0] pipe_dat_d [2][RD_LATENCY];
    logic [XLEN-1:0] pipe_dat_q [2][RD_LATENCY];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            pipe_vld_d[0][p] = rd_en[p];
            pipe_dat_d[p][0] = rd_word[p];
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_d[i][p] = pipe_vld_q[i-1][p];
                pipe_dat_d[p][i] = pipe_dat_q[p][i-1];
            end
            if (!pipe_vld_d[RD_LATENCY-1][p]) begin
                pipe_dat_d[p][RD_LATENCY-1] = pipe_dat_q[p][RD_LATENCY-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]    <= '0;
                pipe_dat_q[0][i] <= '0;
                pipe_dat_q[1][i] <= '0;
            end
        end else begin
            ack_q <= ack_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]    <= pipe_vld_d[i];
                pipe_dat_q[0][i] <= pipe_dat_d[0][i];
                pipe_dat_q[1][i] <= pipe_dat_d[1][i];
            end
        end
    end

    assign a_ack_o   = ack_q[0];
    assign b_ack_o   = ack_q[1];
    assign a_valid_o = pipe_vld_q[RD_LATENCY-1][0];
    assign b_valid_o = pipe_vld_q[RD_LATENCY-1][1];
    assign a_data_o  = pipe_dat_q[0][RD_LATENCY-1];
    assign b_data_o  = pipe_dat_q[1][RD_LATENCY-1];

endmodule

// File: tb/tb_peripheral_dpram_generic_biu.sv
// Purpose : directed bench for peripheral_dpram_generic_biu (XLEN=32, ALEN=4, RD_LATENCY=2).
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpres: none; DUT never stalls, so every step is a fixed number of cycles.
module tb_peripheral_dpram_generic_biu;

    localparam int ALEN = 4;
    localparam int XLEN = 32;
    localparam int LAT  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_req_i, a_we_i, b_req_i, b_we_i;
    logic [3:0]        a_be_i, b_be_i;
    logic [ALEN-1:0]   a_addr_i, b_addr_i;
    logic [XLEN-1:0]   a_data_i, b_data_i;
    logic              a_ack_o, a_valid_o, b_ack_o, b_valid_o;
    logic [XLEN-1:0]   a_data_o, b_data_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    peripheral_dpram_generic_biu #(
        .ALEN(ALEN), .XLEN(XLEN), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req_i(a_req_i), .a_we_i(a_we_i), .a_be_i(a_be_i), .a_addr_i(a_addr_i),
        .a_data_i(a_data_i), .a_ack_o(a_ack_o), .a_valid_o(a_valid_o), .a_data_o(a_data_o),
        .b_req_i(b_req_i), .b_we_i(b_we_i), .b_be_i(b_be_i), .b_addr_i(b_addr_i),
        .b_data_i(b_data_i), .b_ack_o(b_ack_o), .b_valid_o(b_valid_o), .b_data_o(b_data_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        a_req_i = 0; a_we_i = 0; a_be_i = 4'h0; a_addr_i = '0; a_data_i = '0;
        b_req_i = 0; b_we_i = 0; b_be_i = 4'h0; b_addr_i = '0; b_data_i = '0;
    endtask

    task automatic a_op(input logic w, input logic [ALEN-1:0] ad, input logic [31:0] d, input logic [3:0] be);
        a_req_i = 1; a_we_i = w; a_addr_i = ad; a_data_i = d; a_be_i = be;
    endtask

    task automatic b_op(input logic w, input logic [ALEN-1:0] ad, input logic [31:0] d, input logic [3:0] be);
        b_req_i = 1; b_we_i = w; b_addr_i = ad; b_data_i = d; b_be_i = be;
    endtask

    logic [31:0] exp5;

    initial begin
        idle();
        rst = 0;
        tick(); tick();
        rst = 1;

        // Preload mem[3] through port B.
        b_op(1, 4'd3, 32'h11111111, 4'hF);
        tick();
        chk("preload_b_ack", {31'b0, b_ack_o}, 32'h1);
        idle();
        tick();

        // 1: write attempts while in reset are ignored.
        rst = 0;
        a_op(1, 4'd3, 32'hDEADBEEF, 4'hF);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_a_ack", {31'b0, a_ack_o}, 32'h0);
            chk("rst_a_valid", {31'b0, a_valid_o}, 32'h0);
            chk("rst_a_data", a_data_o, 32'h0);
        end
        chk("rst_b_outs", {b_ack_o, b_valid_o, b_data_o[29:0]}, 32'h0);
        rst = 1;
        idle();
        tick();
        a_op(0, 4'd3, 32'h0, 4'h0);
        tick();
        idle();
        chk("rd3_not_yet", {31'b0, a_valid_o}, 32'h0);
        tick();
        chk("rd3_valid", {31'b0, a_valid_o}, 32'h1);
        chk("rd3_data", a_data_o, 32'h11111111);
        tick();
        chk("rd3_valid_pulse", {31'b0, a_valid_o}, 32'h0);
        chk("rd3_data_hold", a_data_o, 32'h11111111);

        // 2: full write then byte-0 write, then cross-port read.
        a_op(1, 4'd5, 32'hA5A5A5A5, 4'hF);
        tick();
        chk("w5_ack1", {31'b0, a_ack_o}, 32'h1);
        a_op(1, 4'd5, 32'h000000FF, 4'h1);
        tick();
        chk("w5_ack2", {31'b0, a_ack_o}, 32'h1);
        chk("w5_no_valid", {31'b0, a_valid_o}, 32'h0);
        idle();
        b_op(0, 4'd5, 32'h0, 4'h0);
        tick();
        chk("w5_ack_drop", {31'b0, a_ack_o}, 32'h0);
        idle();
        tick();
        chk("r5_valid", {31'b0, b_valid_o}, 32'h1);
        chk("r5_data", b_data_o, 32'hA5A5A5FF);

        // 3: back-to-back reads on B.
        for (int i = 0; i < 4; i++) begin
            a_op(1, 4'(i), 32'h01010101 * i, 4'hF);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            b_op(0, 4'(i), 32'h0, 4'h0);
            tick();
            if (i == 0) begin
                chk("b2b_first_gap", {31'b0, b_valid_o}, 32'h0);
            end else begin
                chk("b2b_valid", {31'b0, b_valid_o}, 32'h1);
                chk("b2b_data", b_data_o, 32'h01010101 * (i - 1));
            end
        end
        idle();
        tick();
        chk("b2b_valid_last", {31'b0, b_valid_o}, 32'h1);
        chk("b2b_data_last", b_data_o, 32'h03030303);
        tick();
        chk("b2b_valid_end", {31'b0, b_valid_o}, 32'h0);

        // 4: same-cycle write/write collision, A wins shared lanes.
        a_op(1, 4'd7, 32'h0, 4'hF);
        tick();
        idle();
        a_op(1, 4'd7, 32'h11223344, 4'h3);
        b_op(1, 4'd7, 32'hAABBCCDD, 4'h6);
        tick();
        chk("ww_acks", {30'b0, a_ack_o, b_ack_o}, 32'h3);
        idle();
        a_op(0, 4'd7, 32'h0, 4'h0);
        tick();
        idle();
        tick();
        chk("ww_data", a_data_o, 32'h00BB3344);

        // 5: cross-port read/write collision.
`ifdef PERIPHERAL_DPRAM_WRITE_THROUGH_EN
        exp5 = 32'hCAFEF00D;
`else
        exp5 = 32'h12345678;
`endif
        a_op(1, 4'd9, 32'h12345678, 4'hF);
        tick();
        a_op(1, 4'd9, 32'hCAFEF00D, 4'hF);
        b_op(0, 4'd9, 32'h0, 4'h0);
        tick();
        idle();
        tick();
        chk("rw_valid", {31'b0, b_valid_o}, 32'h1);
        chk("rw_data", b_data_o, exp5);
        b_op(0, 4'd9, 32'h0, 4'h0);
        tick();
        idle();
        tick();
        chk("rw_after", b_data_o, 32'hCAFEF00D);

        // 6: reset flushes an in-flight read.
        a_op(0, 4'd2, 32'h0, 4'h0);
        tick();
        idle();
        rst = 0;
        tick();
        chk("flush_valid0", {31'b0, a_valid_o}, 32'h0);
        chk("flush_data0", a_data_o, 32'h0);
        rst = 1;
        tick();
        chk("flush_valid1", {31'b0, a_valid_o}, 32'h0);
        chk("flush_data1", a_data_o, 32'h0);
        a_op(0, 4'd2, 32'h0, 4'h0);
        tick();
        idle();
        tick();
        chk("post_flush_valid", {31'b0, a_valid_o}, 32'h1);
        chk("post_flush_data", a_data_o, 32'h02020202);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/peripheral_dpram_generic_biu.md
Name: peripheral_dpram_generic_biu

Overview:
True dual-port, byte-enabled, latency-configurable RAM bus functional model. It is the parametrised successor to the single-port generic RAM BIU. Two independent ports (A, B) share one memory array, and each port has a registered write acknowledge, a pipelined read-valid strobe and deterministic collision rules. It is used behind the BIU in testbenches and FPGA prototypes where instruction and data sides access one memory.

Parameters:
ALEN, 10, address width in words; depth = 2**ALEN.
XLEN, 64, data width; must be a multiple of 8.
RD_LATENCY, 1, cycles from accepted read to valid data; legal range 1..4.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-low reset
a_req_i  input  1  port A request
a_we_i  input  1  port A write (1) / read (0)
a_be_i  input  XLEN/8  port A byte enables, one per byte lane
a_addr_i  input  ALEN  port A word address
a_data_i  input  XLEN  port A write data
a_ack_o  output  1  port A write acknowledge
a_valid_o  output  1  port A read data valid
a_data_o  output  XLEN  port A read data
b_req_i, b_we_i, b_be_i, b_addr_i, b_data_i, b_ack_o, b_valid_o, b_data_o: same as port A, for port B

Behaviour:
- Reset: clk and rst are as already decided; one clock, synchronous active-low reset. While rst=0 at a clock edge:
  - a/b_ack_o=0, a/b_valid_o=0, a/b_data_o='0.
  - Read pipeline is flushed; in-flight reads are discarded and never produce valid.
  - Requests are ignored and memory is not written.
  - Memory contents are not reset and keep their values across reset.
- Acceptance: a request is accepted on any edge with rst=1 and req=1. There is no backpressure, so one request per port per cycle.
- Write (req=1, we=1):
  - Each byte lane k with be[k]=1 is updated at that edge: mem[addr][8k+:8] <= data[8k+:8]. Lanes with be[k]=0 are unchanged.
  - ack_o=1 for exactly one cycle, the cycle after acceptance. It is asserted even when be is all zero.
  - valid_o is not asserted for writes.
- Read (req=1, we=0):
  - Memory is sampled at the accept edge.
  - data_o and valid_o=1 appear exactly RD_LATENCY cycles after acceptance, and valid_o is a 1-cycle pulse.
  - be is ignored on reads; the full word is returned.
- Read pipeline: per port, an RD_LATENCY-deep shift register of {valid, data}. Back-to-back reads give back-to-back valids in order.
- data_o holding: when valid_o=0, data_o holds its last valid value (not zeroed), except on reset.
- Collision, write/write to the same address in the same cycle: for each byte lane enabled on both ports, port A wins. Lanes enabled on only one port take that port's data. Both ports receive ack.
- Collision, read/write across ports to the same address in the same cycle: read-first; the read returns the pre-write contents. Overridden by the optional feature below.
- Same-port read-after-write on consecutive cycles returns the new data.
- Address wraps naturally modulo 2**ALEN; no out-of-range error.
- Elaboration checks: fatal error if XLEN%8!=0 or RD_LATENCY is outside 1..4.

Optional Feature:
PERIPHERAL_DPRAM_WRITE_THROUGH_EN:
- Defined: on a cross-port read/write collision at the same address in the same cycle, the read returns the merged word. Written lanes come from the writer's data (A-over-B if both write); unwritten lanes come from the old contents. Latency is unchanged.
- Undefined: read-first behaviour as in Behaviour.

Test Plan:
1. Reset, XLEN=32, ALEN=4, RD_LATENCY=2. Hold rst=0 for 3 cycles with a_req_i=1, a_we_i=1, addr 3, data 0xDEADBEEF, then release and read addr 3 -> no ack during reset; all outputs 0; mem[3] unchanged from its preload of 0x11111111.
2. A writes addr 5 data 0xA5A5A5A5 be 0xF, then A writes addr 5 data 0x000000FF be 0x1, then B reads addr 5 -> a_ack_o pulses at cycles +1 and +2; b_valid_o=1 two cycles after the read with b_data_o=0xA5A5A5FF.
3. B issues reads of addr 0, 1, 2, 3 on consecutive cycles; mem[i]=i*0x01010101 -> b_valid_o high for 4 consecutive cycles starting 2 cycles after the first read, with data 0x00000000, 0x01010101, 0x02020202, 0x03030303.
4. Same cycle: A writes addr 7 data 0x11223344 be 0x3, B writes addr 7 data 0xAABBCCDD be 0x6; old mem[7]=0 -> mem[7]=0x00BB3344 and both acks pulse.
5. Same cycle: A writes addr 9 data 0xCAFEF00D be 0xF, B reads addr 9; old mem[9]=0x12345678 -> b_data_o=0x12345678 without the macro, 0xCAFEF00D with PERIPHERAL_DPRAM_WRITE_THROUGH_EN.
6. A reads addr 2, and rst=0 is asserted in the next cycle for 1 cycle -> a_valid_o never asserts for that read and a_data_o=0; a subsequent read of addr 2 returns the correct value after 2 cycles.
